demultiplex: RTL and testbench
==============================

DEMULTIPLEX -- requirements
Module: demultiplex

Interface
REQ-001 SHALL have parameter W, default 8: payload width in bits.
REQ-002 SHALL have parameter N, default 2: number of output channels; legal range 2..256.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port s_stb, input, 1: input beat valid.
REQ-006 SHALL have port s_dat, input, $clog2(N)+W: input beat.
- Bits [W-1:0] are the payload.
- The upper $clog2(N) bits are the destination index idx.
REQ-007 SHALL have port s_rdy, output, 1: input beat accepted.
REQ-008 SHALL have port m_stb, output, N: per-channel output valid.
REQ-009 SHALL have port m_dat, output, N*W: channel k payload at [k*W+:W].
REQ-010 SHALL have port m_rdy, input, N: per-channel output ready.
REQ-011 SHALL have port err, output, 1: one-cycle pulse on an out-of-range drop.
REQ-012 SHALL have port drops, output, 8: saturating count of dropped beats.

Function
REQ-013 SHALL transfer on a port only in a cycle where its stb and rdy are both 1.
REQ-014 SHALL give each channel an independent 2-entry FIFO (slots plus occupancy count 0..2).
REQ-015 SHALL drive s_rdy combinationally:
- 1 when idx >= N;
- otherwise 1 iff channel idx count != 2.
- s_rdy SHALL NOT depend on m_rdy or on s_stb.
REQ-016 SHALL push the payload into FIFO idx on an accepted beat with idx < N.
REQ-017 SHALL give 1-cycle latency: a beat accepted at edge k makes m_stb[idx]=1 after edge k, with no combinational s_dat->m_dat path.
REQ-018 SHALL drive m_stb[k]=1 iff channel k count > 0, with m_dat[k*W+:W] equal to that FIFO's head.
REQ-019 SHALL pop channel k's head on an m_stb[k] & m_rdy[k] transfer.
REQ-020 SHALL preserve arrival order within each channel; channels SHALL be mutually independent, so a stalled channel never blocks the others.
REQ-021 SHALL, when push and pop hit the same channel in one cycle:
- at count 1, leave count at 1 with the new beat as head;
- at count 0, not pop, since m_stb=0.
REQ-022 SHALL keep s_rdy=0 for a full channel even when that channel pops in the same cycle (no same-cycle pass-through).
REQ-023 SHALL sustain one beat per cycle per channel when m_rdy is held high.
REQ-024 SHALL drop an accepted beat with idx >= N (possible only when N is not a power of two):
- no FIFO change;
- err=1 in the following cycle only;
- drops incremented, saturating at 255.
REQ-025 SHALL produce back-to-back err pulses for consecutive illegal beats, one per beat.
REQ-026 SHALL hold m_dat stable while m_stb[k]=1 and m_rdy[k]=0.

Reset
REQ-027 SHALL, while rst=0, immediately force:
- all FIFO counts to 0;
- m_stb to 0;
- err to 0;
- drops to 0.
REQ-028 SHALL discard FIFO contents when reset is asserted mid-operation; no beat SHALL reappear after release.
REQ-029 SHALL reset m_dat to 0.
REQ-030 SHALL drive s_rdy during reset per REQ-015 with all counts 0.
REQ-031 SHALL resume normal operation on the first rising edge after rst returns to 1.

Verification (W=8, N=3)
REQ-032 SHALL cover basic routing:
- stimulus: s_dat={2'd2,8'hA5}, s_stb=1 for one cycle, m_rdy=3'b111;
- response: s_rdy=1, and the next cycle m_stb=3'b100 with m_dat[23:16]=8'hA5;
- the cycle after, m_stb=0.
REQ-033 SHALL cover backpressure:
- stimulus: m_rdy[1]=0, then beats 8'h11, 8'h22, 8'h33 sent to index 1;
- response: the first two are accepted and s_rdy=0 on the third;
- after m_rdy[1]=1, channel 1 outputs 11, 22, 33 in order with no loss.
REQ-034 SHALL cover channel independence:
- stimulus: channel 0 filled and m_rdy[0]=0, with a continuous stream to channel 2;
- response: channel 2 sustains one beat per cycle, and m_dat[7:0] stays constant.
REQ-035 SHALL cover the illegal index:
- stimulus: s_dat={2'd3,8'hFF}, s_stb=1;
- response: s_rdy=1, m_stb=0, err pulses for exactly one cycle, drops=1.
- Follow with 300 illegal beats; response: drops=255.
REQ-036 SHALL cover reset mid-operation:
- stimulus: two entries queued on channel 1, rst pulsed low asynchronously;
- response: m_stb=0 immediately, drops=0;
- after release, no stale beat appears and a new beat routes per REQ-032.

Source files
------------

// File: rtl/demultiplex_if.sv
// Stream bus for the demultiplexer: one indexed input port and N output channels.
// The slave modport is the demultiplexer's view; master is the driver/sink side.
interface demultiplex_if #(
  parameter int W = 8,
  parameter int N = 2
);
  localparam int IW = $clog2(N);

  logic              s_stb;
  logic [IW+W-1:0]   s_dat;
  logic              s_rdy;
  logic [N-1:0]      m_stb;
  logic [N*W-1:0]    m_dat;
  logic [N-1:0]      m_rdy;

  modport slave  (input  s_stb, s_dat, m_rdy, output s_rdy, m_stb, m_dat);
  modport master (output s_stb, s_dat, m_rdy, input  s_rdy, m_stb, m_dat);
endinterface

// File: rtl/demultiplex.sv
// Routes each input beat to one of N channels by its upper index bits.
// Every channel owns a 2-entry FIFO; out-of-range beats are dropped and counted.
module demultiplex #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst,
  demultiplex_if.slave       bus,
  output logic               err,
  output logic [7:0]         drops
);
  localparam int IW = $clog2(N);

  logic [W-1:0]  payload;
  logic [IW-1:0] idx;
  logic [IW:0]   idx_ext;
  logic          in_range;
  logic [N-1:0]  full;
  logic          sel_full;
  logic          accept;

  assign payload  = bus.s_dat[W-1:0];
  assign idx      = bus.s_dat[IW+W-1:W];
  assign idx_ext  = {1'b0, idx};
  assign in_range = idx_ext < (IW+1)'(N);

  always_comb begin
    sel_full = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_ext == (IW+1)'(k)) sel_full = full[k];
    end
  end

  // Ready depends only on the addressed channel's occupancy, never on m_rdy.
  assign bus.s_rdy = !in_range || !sel_full;
  assign accept    = bus.s_stb && bus.s_rdy;

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign push    = accept && in_range && (idx_ext == (IW+1)'(k));
    assign pop     = (cnt != 2'd0) && bus.m_rdy[k];
    assign full[k] = (cnt == 2'd2);

    assign bus.m_stb[k]         = (cnt != 2'd0);
    assign bus.m_dat[k*W +: W]  = head;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (cnt == 2'd0) begin
              head <= payload;
              cnt  <= 2'd1;
            end else begin
              tail <= payload;
              cnt  <= 2'd2;
            end
          end
          2'b01: begin
            head <= tail;
            cnt  <= cnt - 2'd1;
          end
          // Push+pop only reachable at count 1: new beat becomes head.
          2'b11: head <= payload;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err   <= 1'b0;
      drops <= '0;
    end else begin
      err <= accept && !in_range;
      if (accept && !in_range && drops != 8'hFF) drops <= drops + 8'd1;
    end
  end
endmodule

// File: tb/tb_demultiplex.sv
// Scoreboard bench for demultiplex with W=8, N=3: per-channel expected queues are
// filled on accepted beats and drained on output transfers.
module tb_demultiplex;
  localparam int W = 8;
  localparam int N = 3;

  logic       clk;
  logic       rst;
  logic       err;
  logic [7:0] drops;

  int total;
  int bad;

  demultiplex_if #(.W(W), .N(N)) bus ();

  demultiplex #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err   (err),
    .drops (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0] q [N][$];
  int         exp_err;
  int         exp_drops;

  always @(posedge clk or negedge rst) begin
    int  ix;
    bit  acc;
    if (!rst) begin
      for (int k = 0; k < N; k++) q[k].delete();
      exp_err   = 0;
      exp_drops = 0;
    end else begin
      ix  = int'(bus.s_dat[9:8]);
      acc = bus.s_stb && ((ix >= N) || (q[ix].size() < 2));
      for (int k = 0; k < N; k++) begin
        if (q[k].size() > 0 && bus.m_rdy[k]) void'(q[k].pop_front());
      end
      exp_err = (acc && ix >= N) ? 1 : 0;
      if (acc && ix < N) q[ix].push_back(bus.s_dat[7:0]);
      if (acc && ix >= N && exp_drops < 255) exp_drops++;
    end
  end

  // Mid-cycle comparison against the model state
  always @(negedge clk) begin
    int         ix;
    logic [2:0] estb;
    ix = int'(bus.s_dat[9:8]);
    check_eq("s_rdy", 32'(bus.s_rdy), 32'((ix >= N) || (q[ix].size() < 2)));
    estb = '0;
    for (int k = 0; k < N; k++) begin
      estb[k] = q[k].size() > 0;
      if (q[k].size() > 0) check_eq($sformatf("m_dat%0d", k), 32'(bus.m_dat[k*W +: W]), 32'(q[k][0]));
    end
    check_eq("m_stb", 32'(bus.m_stb), 32'(estb));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("drops", 32'(drops), 32'(exp_drops));
  end

  task automatic drive(input logic stb, input logic [1:0] ix, input logic [7:0] d, input logic [2:0] rdy);
    @(posedge clk);
    #1;
    bus.s_stb = stb;
    bus.s_dat = {ix, d};
    bus.m_rdy = rdy;
  endtask

  task automatic idle(input int n, input logic [2:0] rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'h00, rdy);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst       = 1'b0;
    bus.s_stb = 1'b0;
    bus.s_dat = '0;
    bus.m_rdy = 3'b111;
    #1;
    check_eq("rst_m_stb", 32'(bus.m_stb), 32'd0);
    check_eq("rst_m_dat", 32'(bus.m_dat), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_drops", 32'(drops), 32'd0);
    check_eq("rst_s_rdy", 32'(bus.s_rdy), 32'd1);
    #22 rst = 1'b1;

    // Basic routing
    idle(2, 3'b111);
    drive(1'b1, 2'd2, 8'hA5, 3'b111);
    idle(3, 3'b111);

    // Backpressure on channel 1; third beat held until accepted
    idle(1, 3'b101);
    drive(1'b1, 2'd1, 8'h11, 3'b101);
    drive(1'b1, 2'd1, 8'h22, 3'b101);
    drive(1'b1, 2'd1, 8'h33, 3'b101);
    drive(1'b1, 2'd1, 8'h33, 3'b101);
    drive(1'b1, 2'd1, 8'h33, 3'b111);
    drive(1'b1, 2'd1, 8'h33, 3'b111);
    idle(4, 3'b111);

    // Channel 0 stalled while channel 2 streams
    drive(1'b1, 2'd0, 8'hC0, 3'b110);
    drive(1'b1, 2'd0, 8'hC1, 3'b110);
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd2, 8'(8'h50 + i), 3'b110);
    idle(4, 3'b111);

    // Illegal index, single then a long run to saturation
    drive(1'b1, 2'd3, 8'hFF, 3'b111);
    idle(3, 3'b111);
    for (int i = 0; i < 300; i++) drive(1'b1, 2'd3, 8'(i), 3'b111);
    idle(2, 3'b111);
    check_eq("drops_sat", 32'(drops), 32'd255);

    // Reset mid-operation with two beats queued on channel 1
    drive(1'b1, 2'd1, 8'h44, 3'b101);
    drive(1'b1, 2'd1, 8'h55, 3'b101);
    idle(1, 3'b101);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("mid_rst_m_stb", 32'(bus.m_stb), 32'd0);
    check_eq("mid_rst_drops", 32'(drops), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    #12 rst = 1'b1;
    idle(3, 3'b111);
    drive(1'b1, 2'd2, 8'hA5, 3'b111);
    idle(3, 3'b111);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom));
    idle(5, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
